// File: rtl/rgb_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_dispense_ctrl
//
// Initiator side of the RGB dispense-timer handshake. A start request latches
// the three per-channel cycle counts and pulses trigger once. The block then
// follows the timer's level-held flags through the R, G and B phases, and it
// enables the matching motor while each phase is running. A per-phase watchdog
// traps a timer that never answers, and unexpected flag patterns trap a timer
// that breaks the protocol. Both cases latch a sticky error.
//
// Optional feature macro: ABORT_EN
//   When it is defined, the block has an abort input and a timer_rst_n output.
//   An abort in any non-IDLE state returns the block to IDLE. It also pulses
//   timer_rst_n low for one cycle so that the timer is resynchronised.
//   When it is undefined, only reset can leave ERR.
//
// Parameters
//   CW       width of each per-channel cycle count
//   TIMEOUT  max clk cycles in one RUN phase before error (must exceed 2^CW)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   start        request pulse, sampled only in IDLE
//   req_r/g/b    requested per-channel cycle counts
//   flags_in     timer flags {R,G,B}, level-held by the timer
//   abort        (ABORT_EN) return to IDLE from any non-IDLE state
//   timer_rst_n  (ABORT_EN) one-cycle low pulse on abort, idles high
//   trigger      one-cycle pulse that starts the timer sequence
//   ciclos_R/G/B latched counts presented to the timer
//   motor_en     {R,G,B} motor enables, at most one bit high
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a sequence completes
//   error        sticky fault indicator
// -----------------------------------------------------------------------------
module rgb_dispense_ctrl #(
    parameter int CW      = 5,
    parameter int TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] req_r,
    input  logic [CW-1:0] req_g,
    input  logic [CW-1:0] req_b,
    input  logic [2:0]    flags_in,
`ifdef ABORT_EN
    input  logic          abort,
    output logic          timer_rst_n,
`endif
    output logic          trigger,
    output logic [CW-1:0] ciclos_R,
    output logic [CW-1:0] ciclos_G,
    output logic [CW-1:0] ciclos_B,
    output logic [2:0]    motor_en,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN_R = 3'd2,
        RUN_G = 3'd3,
        RUN_B = 3'd4,
        FIN   = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WDW-1:0]   r_wd;
    logic [WDW-1:0]   w_wd_nxt;
    logic [WDW-1:0]   w_wd_inc;
    logic             w_wd_expire;

    logic [CW-1:0]    r_ciclos_R;
    logic [CW-1:0]    r_ciclos_G;
    logic [CW-1:0]    r_ciclos_B;
    logic             r_trigger;
    logic [2:0]       r_motor_en;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    // Next values of the registered outputs. They are decoded from the next
    // state, so the outputs change in the same cycle that the state changes.
    logic             w_trigger_nxt;
    logic [2:0]       w_motor_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_error_nxt;

`ifdef ABORT_EN
    logic             w_abort_take;
    logic             r_timer_rst_n;
`endif

    function automatic logic f_is_run(input state_t s);
        return (s == RUN_R) || (s == RUN_G) || (s == RUN_B);
    endfunction

    assign w_wd_inc    = r_wd + WDW'(1);
    // The watchdog expires on the edge that closes the TIMEOUT-th RUN cycle.
    assign w_wd_expire = (w_wd_inc == WDW'(TIMEOUT));

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------- next state / next outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_wd_nxt      = r_wd;
        w_trigger_nxt = 1'b0;
        w_motor_nxt   = 3'b000;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
`ifdef ABORT_EN
        w_abort_take  = 1'b0;
`endif

        // The exit flag is tested before the watchdog, so the exit wins when
        // both happen in the same cycle.
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = ARM;
            end
            ARM: begin
                w_state_nxt = RUN_R;
            end
            RUN_R: begin
                if (flags_in == 3'b100)      w_state_nxt = RUN_G;
                else if (flags_in != 3'b000) w_state_nxt = ERR;
                else if (w_wd_expire)        w_state_nxt = ERR;
            end
            RUN_G: begin
                // The R flag can still be held from the previous phase.
                if (flags_in == 3'b010)                              w_state_nxt = RUN_B;
                else if (flags_in != 3'b000 && flags_in != 3'b100)   w_state_nxt = ERR;
                else if (w_wd_expire)                                w_state_nxt = ERR;
            end
            RUN_B: begin
                if (flags_in == 3'b001)                              w_state_nxt = FIN;
                else if (flags_in != 3'b000 && flags_in != 3'b010)   w_state_nxt = ERR;
                else if (w_wd_expire)                                w_state_nxt = ERR;
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

`ifdef ABORT_EN
        // Abort overrides start, flags and watchdog. It has no effect in IDLE.
        if (abort && r_state != IDLE) begin
            w_state_nxt  = IDLE;
            w_abort_take = 1'b1;
        end
`endif

        // The watchdog restarts on entry to each RUN phase and counts while
        // the block stays in that phase.
        if (f_is_run(w_state_nxt) && w_state_nxt != r_state) begin
            w_wd_nxt = '0;
        end else if (f_is_run(r_state)) begin
            w_wd_nxt = w_wd_inc;
        end

        w_trigger_nxt = (w_state_nxt == ARM);
        w_busy_nxt    = (w_state_nxt != IDLE);
        w_done_nxt    = (w_state_nxt == FIN);
        w_error_nxt   = (w_state_nxt == ERR);

        // A zero count keeps its motor off, but the phase still waits for
        // its flag.
        case (w_state_nxt)
            RUN_R:   w_motor_nxt = (r_ciclos_R != '0) ? 3'b100 : 3'b000;
            RUN_G:   w_motor_nxt = (r_ciclos_G != '0) ? 3'b010 : 3'b000;
            RUN_B:   w_motor_nxt = (r_ciclos_B != '0) ? 3'b001 : 3'b000;
            default: w_motor_nxt = 3'b000;
        endcase
    end

    // ---------------------------------------------------------- output regs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd       <= '0;
            r_ciclos_R <= '0;
            r_ciclos_G <= '0;
            r_ciclos_B <= '0;
            r_trigger  <= 1'b0;
            r_motor_en <= 3'b000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wd       <= w_wd_nxt;
            r_trigger  <= w_trigger_nxt;
            r_motor_en <= w_motor_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            // Counts are captured only when a request is accepted. A start
            // while busy leaves them untouched.
            if (r_state == IDLE && start) begin
                r_ciclos_R <= req_r;
                r_ciclos_G <= req_g;
                r_ciclos_B <= req_b;
            end
        end
    end

`ifdef ABORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer_rst_n <= 1'b1;
        end else begin
            r_timer_rst_n <= ~w_abort_take;
        end
    end

    assign timer_rst_n = r_timer_rst_n;
`endif

    assign trigger  = r_trigger;
    assign ciclos_R = r_ciclos_R;
    assign ciclos_G = r_ciclos_G;
    assign ciclos_B = r_ciclos_B;
    assign motor_en = r_motor_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_rgb_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgb_dispense_ctrl
//
// Directed, self-checking bench for rgb_dispense_ctrl. The bench drives the
// timer flags by hand, step by step, as a well-behaved or faulty timer would.
// All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_rgb_dispense_ctrl;

    localparam int CW      = 5;
    localparam int TIMEOUT = 40;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] req_r;
    logic [CW-1:0] req_g;
    logic [CW-1:0] req_b;
    logic [2:0]    flags_in;
    logic          trigger;
    logic [CW-1:0] ciclos_R;
    logic [CW-1:0] ciclos_G;
    logic [CW-1:0] ciclos_B;
    logic [2:0]    motor_en;
    logic          busy;
    logic          done;
    logic          error;
`ifdef ABORT_EN
    logic          abort;
    logic          timer_rst_n;
`endif

    int checks = 0;
    int errors = 0;

    rgb_dispense_ctrl #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .req_r       (req_r),
        .req_g       (req_g),
        .req_b       (req_b),
        .flags_in    (flags_in),
`ifdef ABORT_EN
        .abort       (abort),
        .timer_rst_n (timer_rst_n),
`endif
        .trigger     (trigger),
        .ciclos_R    (ciclos_R),
        .ciclos_G    (ciclos_G),
        .ciclos_B    (ciclos_B),
        .motor_en    (motor_en),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. Outputs are sampled and inputs are changed 1 ns
    // after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input int g, input int b);
        req_r = CW'(r);
        req_g = CW'(g);
        req_b = CW'(b);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        flags_in = 3'b000;
        set_req(0, 0, 0);
`ifdef ABORT_EN
        abort    = 1'b0;
`endif

        // ---------------- reset state
        #3;
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_motor",   32'(motor_en), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_error",   32'(error), 0);
        chk("rst_ciclos",  {17'd0, ciclos_R, ciclos_G, ciclos_B}, 0);
`ifdef ABORT_EN
        chk("rst_trst",    32'(timer_rst_n), 1);
`endif
        tick();
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // ---------------- normal sequence (3,5,2)
        set_req(3, 5, 2);
        start = 1'b1;
        tick();                                   // ARM
        start = 1'b0;
        chk("n_trigger",  32'(trigger), 1);
        chk("n_arm_busy", 32'(busy), 1);
        chk("n_cR", 32'(ciclos_R), 3);
        chk("n_cG", 32'(ciclos_G), 5);
        chk("n_cB", 32'(ciclos_B), 2);
        chk("n_arm_motor", 32'(motor_en), 'b000);
        tick();                                   // RUN_R
        chk("n_trig_low", 32'(trigger), 0);
        chk("n_motor_R",  32'(motor_en), 'b100);
        tick();
        tick();
        chk("n_motor_R_hold", 32'(motor_en), 'b100);
        flags_in = 3'b100;                        // R done after 3 cycles
        tick();                                   // RUN_G
        chk("n_motor_G", 32'(motor_en), 'b010);
        repeat (4) tick();                        // stale R flag tolerated
        chk("n_motor_G_hold", 32'(motor_en), 'b010);
        chk("n_G_err", 32'(error), 0);
        flags_in = 3'b010;
        tick();                                   // RUN_B
        chk("n_motor_B", 32'(motor_en), 'b001);
        tick();                                   // stale G flag tolerated
        chk("n_motor_B_hold", 32'(motor_en), 'b001);
        flags_in = 3'b001;
        tick();                                   // FIN
        chk("n_done",     32'(done), 1);
        chk("n_fin_motor", 32'(motor_en), 'b000);
        chk("n_fin_busy", 32'(busy), 1);
        flags_in = 3'b000;
        tick();                                   // IDLE
        chk("n_done_once", 32'(done), 0);
        chk("n_busy_fall", 32'(busy), 0);
        chk("n_ciclos_keep", {17'd0, ciclos_R, ciclos_G, ciclos_B}, {17'd0, 5'd3, 5'd5, 5'd2});

        // ---------------- zero channels (0,4,0) and start while busy
        set_req(0, 4, 0);
        start = 1'b1;
        tick();                                   // ARM
        start = 1'b0;
        tick();                                   // RUN_R
        chk("z_motor_R", 32'(motor_en), 'b000);
        chk("z_busy",    32'(busy), 1);
        tick();
        flags_in = 3'b100;
        tick();                                   // RUN_G
        chk("z_motor_G", 32'(motor_en), 'b010);
        set_req(9, 9, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_busy_start", {17'd0, ciclos_R, ciclos_G, ciclos_B}, {17'd0, 5'd0, 5'd4, 5'd0});
        chk("z_busy_trig", 32'(trigger), 0);
        flags_in = 3'b010;
        tick();                                   // RUN_B
        chk("z_motor_B", 32'(motor_en), 'b000);
        flags_in = 3'b001;
        tick();                                   // FIN
        chk("z_done", 32'(done), 1);
        flags_in = 3'b000;
        tick();
        chk("z_idle", 32'(busy), 0);

        // ---------------- timeout in RUN_R
        set_req(7, 1, 1);
        start = 1'b1;
        tick();                                   // ARM
        start = 1'b0;
        tick();                                   // RUN_R entry
        repeat (TIMEOUT - 1) tick();
        chk("to_pre_err", 32'(error), 0);
        chk("to_pre_motor", 32'(motor_en), 'b100);
        tick();
        chk("to_err",   32'(error), 1);
        chk("to_motor", 32'(motor_en), 'b000);
        chk("to_busy",  32'(busy), 1);
        set_req(2, 2, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_start_ign", 32'(ciclos_R), 7);
        chk("to_trig",  32'(trigger), 0);
        chk("to_sticky", 32'(error), 1);
        reset = 1'b0;
        #1;
        chk("to_rst_err", 32'(error), 0);
        reset = 1'b1;
        tick();

        // ---------------- exit flag wins against expiry; watchdog cleared per phase
        set_req(4, 4, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                                   // RUN_R entry
        repeat (TIMEOUT - 1) tick();
        flags_in = 3'b100;
        tick();                                   // expiry edge, flag present
        chk("bw_R_exit", 32'(motor_en), 'b010);
        chk("bw_R_err",  32'(error), 0);
        repeat (TIMEOUT - 1) tick();
        chk("bw_G_noerr", 32'(error), 0);
        flags_in = 3'b010;
        tick();
        chk("bw_G_exit", 32'(motor_en), 'b001);
        flags_in = 3'b001;
        tick();
        chk("bw_done", 32'(done), 1);
        flags_in = 3'b000;
        tick();

        // ---------------- protocol error in RUN_R
        set_req(2, 2, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                                   // RUN_R
        flags_in = 3'b001;
        tick();
        chk("pe_err",   32'(error), 1);
        chk("pe_motor", 32'(motor_en), 'b000);
        chk("pe_busy",  32'(busy), 1);
        flags_in = 3'b000;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();

        // ---------------- protocol error in RUN_B (R flag is illegal there)
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flags_in = 3'b100;
        tick();                                   // RUN_G
        flags_in = 3'b010;
        tick();                                   // RUN_B
        flags_in = 3'b100;
        tick();
        chk("peB_err", 32'(error), 1);
        flags_in = 3'b000;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();

        // ---------------- async reset mid RUN_G
        set_req(1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flags_in = 3'b100;
        tick();                                   // RUN_G
        chk("ar_pre_motor", 32'(motor_en), 'b010);
        reset = 1'b0;
        #1;
        chk("ar_motor",  32'(motor_en), 0);
        chk("ar_busy",   32'(busy), 0);
        chk("ar_ciclos", {17'd0, ciclos_R, ciclos_G, ciclos_B}, 0);
        chk("ar_trig",   32'(trigger), 0);
        chk("ar_done",   32'(done), 0);
        chk("ar_error",  32'(error), 0);
        flags_in = 3'b000;
        reset = 1'b1;
        tick();
        tick();
        chk("ar_idle", 32'(busy), 0);

`ifdef ABORT_EN
        // ---------------- abort in RUN_B, then a clean sequence
        set_req(2, 2, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flags_in = 3'b100;
        tick();
        flags_in = 3'b010;
        tick();                                   // RUN_B
        abort = 1'b1;
        tick();
        abort = 1'b0;
        flags_in = 3'b000;
        chk("ab_busy",  32'(busy), 0);
        chk("ab_motor", 32'(motor_en), 0);
        chk("ab_done",  32'(done), 0);
        chk("ab_trst",  32'(timer_rst_n), 0);
        tick();
        chk("ab_trst_hi", 32'(timer_rst_n), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_trig", 32'(trigger), 1);
        tick();
        flags_in = 3'b100;
        tick();
        flags_in = 3'b010;
        tick();
        flags_in = 3'b001;
        tick();
        chk("ab_done2", 32'(done), 1);
        flags_in = 3'b000;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_dispense_ctrl.md
Name: rgb_dispense_ctrl

Overview:
Initiator side of the RGB dispense-timer handshake. Latches a requested per-channel cycle count and presents it on ciclos_R/G/B. Pulses trigger, then tracks the timer's level-held flags through R -> G -> B. While each phase runs, the block drives the matching motor enable. It reports busy/done/error and has a per-phase watchdog.

Parameters:
CW, 5, width of each per-channel cycle count (matches timer ciclos inputs)
TIMEOUT, 40, max clk cycles allowed in one RUN phase before error; must exceed 2^CW

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
req_r  in  CW  requested red cycle count
req_g  in  CW  requested green cycle count
req_b  in  CW  requested blue cycle count
flags_in  in  3  timer flags {R,G,B}; level-held by timer, cleared to 000 when timer returns to its start state
trigger  out  1  one-cycle pulse starting the timer sequence
ciclos_R  out  CW  latched red count to timer
ciclos_G  out  CW  latched green count to timer
ciclos_B  out  CW  latched blue count to timer
motor_en  out  3  {R,G,B} motor enables
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on sequence completion
error  out  1  sticky fault indicator

Behaviour:
- Reset (async, any time, including mid-sequence): state=IDLE; trigger=0, motor_en=000, busy=0, done=0, error=0, ciclos_*=0, watchdog=0.
- All outputs registered.
- States: IDLE, ARM, RUN_R, RUN_G, RUN_B, FIN, ERR.
- IDLE:
  - start=1 latches req_* into ciclos_* and goes to ARM.
  - start=0 holds IDLE; ciclos_* keep their last values.
- ARM: trigger=1 for exactly this one cycle; next state RUN_R. Latency start -> trigger is 1 cycle.
- RUN_R:
  - motor_en=100 if ciclos_R!=0, else 000.
  - Exit on flags_in==100 -> RUN_G.
  - Tolerated: flags_in==000.
  - Any other nonzero value -> ERR.
- RUN_G:
  - motor_en=010 if ciclos_G!=0.
  - Exit on flags_in==010 -> RUN_B.
  - Tolerated: 100 (stale) and 000.
  - Any other value -> ERR.
- RUN_B:
  - motor_en=001 if ciclos_B!=0.
  - Exit on flags_in==001 -> FIN.
  - Tolerated: 010 and 000.
  - Any other value -> ERR.
- Motor handover: motor_en changes in the same cycle as the state change. There is never more than one bit high.
- FIN: done=1 for one cycle, motor_en=000; next IDLE.
- Watchdog:
  - Width $clog2(TIMEOUT+1).
  - Cleared on entry to each RUN state; increments every RUN cycle.
  - When it reaches TIMEOUT without the exit flag -> ERR.
- ERR:
  - motor_en=000, trigger=0, error=1, busy=1.
  - Held until reset, or until abort when ABORT_EN is defined.
- start while busy: ignored, with no effect on latched counts.
- Simultaneous exit flag and watchdog expiry in the same cycle: the exit flag wins.
- Requests of 0 are legal. The phase still waits for its flag; the motor stays off.

Optional Feature:
Macro ABORT_EN.
- Defined: adds input abort (1b) and output timer_rst_n (1b, reset value 1).
  - abort=1 in any state except IDLE -> next state IDLE: motor_en=000, trigger=0, error cleared, done not pulsed.
  - timer_rst_n driven 0 for exactly one cycle to resynchronise the timer.
  - abort in IDLE has no effect.
  - abort has priority over start, flags and watchdog.
- Undefined: no abort port, no timer_rst_n port; ERR is exited only by reset.

Test Plan:
- Normal sequence: req=(3,5,2), start pulse, timer model obeys the protocol -> trigger high exactly 1 cycle after start; motor_en 100, then 010, then 001 with phase lengths tracking the timer; done pulses once; busy falls the cycle after done.
- Zero channel: req=(0,4,0) -> motor_en stays 000 in RUN_R and RUN_B and is 010 in RUN_G; sequence still completes with done.
- Timeout: timer model never raises flag R -> error=1 at exactly TIMEOUT=40 cycles after entering RUN_R; motor_en=000; further start ignored.
- Protocol error: flags_in=001 during RUN_R -> ERR next cycle, motor_en=000, error=1.
- Busy/reset: start pulsed during RUN_G with req=(9,9,9) -> ciclos_* unchanged; reset asserted mid RUN_G -> all outputs 0 immediately, IDLE after release.
- ABORT_EN: abort in RUN_B -> IDLE next cycle, timer_rst_n low for 1 cycle, no done pulse; fresh start then completes normally.
